// File: rtl/fmul_e4f4_unit.sv
// Two-stage FloPoCo-format multiplier (wE=4, wF=4).
// Stage 1 multiplies and classifies; stage 2 normalizes, rounds and packs.
module fmul_e4f4_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        ce,
    output logic [10:0] r,
    output logic        r_valid,
    output logic        busy
);

    localparam logic [1:0] EXC_ZERO = 2'b00;
    localparam logic [1:0] EXC_NORM = 2'b01;
    localparam logic [1:0] EXC_INF  = 2'b10;
    localparam logic [1:0] EXC_NAN  = 2'b11;

    logic        v1_q;
    logic        s1_sign_q, s1_sign_d;
    logic [5:0]  s1_exp_q, s1_exp_d;
    logic [9:0]  s1_prod_q, s1_prod_d;
    logic [1:0]  s1_exc_q, s1_exc_d;

    logic        v2_q;
    logic [10:0] s2_res_q, s2_res_d;

    logic        r_valid_q;
    logic [10:0] r_q;

    logic [1:0]  xc, yc;
    logic        any_nan, any_inf, any_zero;

    always_comb begin
        xc        = x[10:9];
        yc        = y[10:9];
        any_zero  = (xc == EXC_ZERO) || (yc == EXC_ZERO);
        any_inf   = (xc == EXC_INF) || (yc == EXC_INF);
        any_nan   = (xc == EXC_NAN) || (yc == EXC_NAN) || (any_zero && any_inf);
        s1_sign_d = x[8] ^ y[8];
        s1_exp_d  = {2'b00, x[7:4]} + {2'b00, y[7:4]} - 6'd7;
        s1_prod_d = {5'b0, 1'b1, x[3:0]} * {5'b0, 1'b1, y[3:0]};
        if (any_nan) begin
            s1_exc_d = EXC_NAN;
        end else if (any_inf) begin
            s1_exc_d = EXC_INF;
        end else if (any_zero) begin
            s1_exc_d = EXC_ZERO;
        end else begin
            s1_exc_d = EXC_NORM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_prod_q <= '0;
            s1_exc_q  <= '0;
        end else begin
            v1_q <= ce;
            if (ce) begin
                s1_sign_q <= s1_sign_d;
                s1_exp_q  <= s1_exp_d;
                s1_prod_q <= s1_prod_d;
                s1_exc_q  <= s1_exc_d;
            end
        end
    end

    logic       hi, guard, sticky, rnd_up;
    logic [3:0] frac_n;
    logic [4:0] frac_sum;
    logic [5:0] exp_n, exp_r;
    logic       ovf, unf;

    // Product in [1,4): bit 9 set means the value reached 2.0
    always_comb begin
        hi       = s1_prod_q[9];
        exp_n    = s1_exp_q + {5'b0, hi};
        frac_n   = hi ? s1_prod_q[8:5] : s1_prod_q[7:4];
        guard    = hi ? s1_prod_q[4] : s1_prod_q[3];
        sticky   = hi ? (|s1_prod_q[3:0]) : (|s1_prod_q[2:0]);
        rnd_up   = guard & (sticky | frac_n[0]);
        frac_sum = {1'b0, frac_n} + {4'b0, rnd_up};
        exp_r    = exp_n + {5'b0, frac_sum[4]};
        unf      = exp_r[5];
        ovf      = !exp_r[5] && exp_r[4];
        if (s1_exc_q == EXC_NAN) begin
            s2_res_d = {EXC_NAN, 1'b0, 8'h00};
        end else if (s1_exc_q == EXC_INF) begin
            s2_res_d = {EXC_INF, s1_sign_q, 8'h00};
        end else if (s1_exc_q == EXC_ZERO) begin
            s2_res_d = {EXC_ZERO, s1_sign_q, 8'h00};
        end else if (ovf) begin
            s2_res_d = {EXC_INF, s1_sign_q, 8'h00};
        end else if (unf) begin
            s2_res_d = {EXC_ZERO, s1_sign_q, 8'h00};
        end else begin
            s2_res_d = {EXC_NORM, s1_sign_q, exp_r[3:0], frac_sum[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q     <= 1'b0;
            s2_res_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_res_q <= s2_res_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_q       <= '0;
        end else begin
            r_valid_q <= v2_q;
            if (v2_q) begin
                r_q <= s2_res_q;
            end
        end
    end

    assign r       = r_q;
    assign r_valid = r_valid_q;
    assign busy    = v1_q | v2_q;

endmodule

// File: tb/tb_fmul_e4f4_unit.sv
// Randomized and directed bench for fmul_e4f4_unit with an arithmetic
// reference model and an issue-time queue for latency tracking.
module tb_fmul_e4f4_unit;

    logic        clk;
    logic        rst_n;
    logic [10:0] x, y;
    logic        ce;
    logic [10:0] r;
    logic        r_valid;
    logic        busy;

    int checks = 0;
    int failures = 0;

    fmul_e4f4_unit dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .ce(ce),
        .r(r), .r_valid(r_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] fmul_ref(input logic [10:0] a, input logic [10:0] b);
        int ca, cb, e, p, q, rem, half, sh;
        logic s;
        ca = int'(a[10:9]);
        cb = int'(b[10:9]);
        s  = a[8] ^ b[8];
        if (ca == 3 || cb == 3 || (ca == 0 && cb == 2) || (ca == 2 && cb == 0))
            return 11'h600;
        if (ca == 2 || cb == 2) return {2'b10, s, 8'h00};
        if (ca == 0 || cb == 0) return {2'b00, s, 8'h00};
        p  = (16 + int'(a[3:0])) * (16 + int'(b[3:0]));
        e  = int'(a[7:4]) + int'(b[7:4]) - 7;
        sh = 4;
        if (p >= 512) begin
            sh = 5;
            e++;
        end
        q    = p >> sh;
        rem  = p % (1 << sh);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q == 32) begin
            q = 16;
            e++;
        end
        if (e > 15) return {2'b10, s, 8'h00};
        if (e < 0) return {2'b00, s, 8'h00};
        return {2'b01, s, e[3:0], q[3:0]};
    endfunction

    function automatic logic [10:0] rand_op();
        int k;
        logic [1:0] c;
        k = $urandom_range(0, 7);
        c = (k < 5) ? 2'b01 : (k == 5) ? 2'b00 : (k == 6) ? 2'b10 : 2'b11;
        return {c, 9'($urandom)};
    endfunction

    typedef struct {
        int          cyc;
        logic [10:0] res;
    } tok_t;

    tok_t        tq[$];
    int          cyc = 0;
    logic [10:0] exp_r = '0;
    logic        exp_v;
    bit          rnd_phase = 0;
    int          rnd_issued = 0;
    int          rnd_pulses = 0;

    // Every accepted operand pair is queued with its issue edge index
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tq.delete();
        end else begin
            cyc++;
            if (ce) begin
                tq.push_back('{cyc, fmul_ref(x, y)});
                if (rnd_phase) rnd_issued++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_r = '0;
            chk("reset_r", 32'(r), 32'h0);
            chk("reset_r_valid", 32'(r_valid), 32'h0);
            chk("reset_busy", 32'(busy), 32'h0);
        end else begin
            exp_v = (tq.size() > 0) && (tq[0].cyc == cyc - 2);
            if (exp_v) begin
                exp_r = tq[0].res;
                void'(tq.pop_front());
            end
            chk("r_valid", 32'(r_valid), 32'(exp_v));
            chk("r", 32'(r), 32'(exp_r));
            chk("busy", 32'(busy), 32'(tq.size() > 0));
            if (rnd_phase && r_valid) rnd_pulses++;
        end
    end

    task automatic run_one(input string name, input logic [10:0] a,
                           input logic [10:0] b, input logic [10:0] e);
        chk({name, "_model"}, 32'(fmul_ref(a, b)), 32'(e));
        @(negedge clk);
        ce = 1'b1; x = a; y = b;
        @(negedge clk);
        ce = 1'b0; x = 11'($urandom); y = 11'($urandom);
        @(negedge clk);
        chk({name, "_early"}, 32'(r_valid), 32'h0);
        @(negedge clk);
        chk({name, "_r"}, 32'(r), 32'(e));
        chk({name, "_rv"}, 32'(r_valid), 32'h1);
        @(negedge clk);
        chk({name, "_hold"}, 32'(r), 32'(e));
    endtask

    initial begin
        rst_n = 1'b0;
        ce = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(negedge clk);
        ce = 1'b1; x = 11'h288; y = 11'h290;
        @(negedge clk);
        ce = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;

        run_one("one_x_two", 11'h270, 11'h280, 11'h280);
        run_one("overflow", 11'h2F0, 11'h2F0, 11'h400);
        run_one("underflow", 11'h200, 11'h200, 11'h000);
        run_one("zero_inf", 11'h000, 11'h400, 11'h600);
        run_one("nan_op", 11'h600, 11'h270, 11'h600);
        run_one("neg_sq", 11'h370, 11'h370, 11'h270);
        run_one("tie_up", 11'h271, 11'h278, 11'h27A);
        run_one("tie_even", 11'h273, 11'h278, 11'h27C);

        @(negedge clk);
        ce = 1'b1; x = 11'h288; y = 11'h290;
        @(negedge clk);
        x = 11'h370; y = 11'h280;
        @(negedge clk);
        x = 11'h271; y = 11'h271;
        @(negedge clk);
        ce = 1'b0;
        chk("b2b_0", 32'(r), 32'h2A8);
        @(negedge clk);
        chk("b2b_1", 32'(r), 32'h380);
        chk("b2b_busy_on", 32'(busy), 32'h1);
        @(negedge clk);
        chk("b2b_2", 32'(r), 32'h272);
        chk("b2b_rv", 32'(r_valid), 32'h1);
        chk("b2b_busy_off", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);

        ce = 1'b1; x = 11'h288; y = 11'h290;
        @(negedge clk);
        ce = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_flight_r", 32'(r), 32'h0);
        run_one("after_rst", 11'h270, 11'h280, 11'h280);

        rnd_phase = 1;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            ce = ($urandom_range(0, 3) != 0);
            x = rand_op();
            y = rand_op();
        end
        @(negedge clk);
        ce = 1'b0;
        repeat (4) @(negedge clk);
        rnd_phase = 0;
        chk("rnd_pulse_count", 32'(rnd_pulses), 32'(rnd_issued));
        chk("rnd_enough", 32'(rnd_issued >= 8000), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmul_e4f4_unit.md
FMUL_E4F4_UNIT -- requirements
Module: fmul_e4f4_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; every register updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port x, input, 11 bits: operand A, FloPoCo word with wE=4, wF=4.
REQ-004 SHALL have port y, input, 11 bits: operand B, same format as x.
REQ-005 SHALL have port ce, input, 1 bit: operand-valid strobe; x/y are sampled on every edge where ce=1.
REQ-006 SHALL have port r, output, 11 bits, registered: the product.
REQ-007 SHALL have port r_valid, output, 1 bit, registered: one-cycle pulse marking a new r.
REQ-008 SHALL have port busy, output, 1 bit: 1 while any pipeline stage holds a valid token.

Function
REQ-009 Word format SHALL be [10:9] exception (00 zero, 01 normal, 10 inf, 11 NaN), [8] sign, [7:4] exponent with bias 7, [3:0] fraction with hidden 1; no subnormals.
REQ-010 The unit SHALL be a 2-stage pipeline. Operands sampled at edge N appear on r with r_valid=1 after edge N+2.
REQ-011 Throughput SHALL be one operation per cycle, with back-to-back ce accepted with no bubbles and no stall path.
REQ-012 Each stage SHALL carry a valid bit; stage 1 valid <= ce; stage 2 valid <= stage 1 valid.
REQ-013 Stage 1 SHALL register: the sign XOR; the 6-bit signed exponent sum ex+ey-7; the 10-bit product of {1,fx}*{1,fy}; and the exception class.
REQ-014 Stage 2 SHALL normalize: if product[9]=1, shift right by 1 and increment the exponent.
REQ-015 Stage 2 SHALL then round the fraction to 4 bits, round-to-nearest-even. A rounding carry SHALL renormalize (fraction 0000, exponent +1).
REQ-016 Exponent after rounding >15 SHALL yield inf with the product sign; exponent field and fraction field 0.
REQ-017 Exponent after rounding <0 SHALL yield zero with the product sign; exponent field and fraction field 0.
REQ-018 Exception priority SHALL be:
- any NaN operand, or zero*inf, gives NaN (sign 0, exponent 0, fraction 0);
- otherwise any inf gives inf;
- otherwise any zero gives signed zero;
- otherwise the normal path.
REQ-019 Non-normal results SHALL have exponent and fraction fields forced to 0.
REQ-020 r SHALL hold its last value when stage 2 is not valid; only a valid stage-2 token updates r.
REQ-021 busy SHALL equal stage 1 valid OR stage 2 valid.
REQ-022 x and y SHALL be don't-care when ce=0 and SHALL NOT affect r.

Reset
REQ-023 While rst_n=0:
- r = 0, r_valid = 0, busy = 0;
- both stage valid bits = 0;
- all datapath registers = 0.
REQ-024 Reset assertion mid-operation SHALL discard in-flight tokens; no r_valid pulse SHALL occur for them after release.
REQ-025 ce SHALL be ignored while rst_n=0. The first edge with rst_n=1 and ce=1 SHALL be a normal issue.

Verification
REQ-026 Single issue, x=0x270 (1.0), y=0x280 (2.0), ce for one cycle: r=0x280 with r_valid=1 exactly after the 2nd edge; r holds afterwards.
REQ-027 Back-to-back issue over 3 consecutive cycles, pairs (0x288,0x290), (0x370,0x280), (0x271,0x271):
- r sequence 0x2A8, 0x380, 0x272;
- r_valid high for 3 consecutive cycles;
- busy drops 2 cycles after the last ce.
REQ-028 Range limits:
- 0x2F0*0x2F0 (overflow) gives 0x400;
- 0x200*0x200 (underflow) gives 0x000;
- 0x000*0x400 (zero*inf) gives 0x600;
- 0x600*0x270 (NaN operand) gives 0x600.
REQ-029 Sign and rounding: 0x370*0x370 gives 0x270.
REQ-030 A tie case SHALL confirm round-half-to-even against a reference model.
REQ-031 Reset mid-flight: issue 0x288*0x290, then pull rst_n low 1 cycle after issue and release:
- r=0 and r_valid=0 throughout;
- no late pulse after release;
- a new issue then completes in 2 cycles.
REQ-032 Random regression: at least 10k random operand pairs with random ce gaps, checked against a bit-accurate software model. Checks SHALL cover latency, r_valid count equal to ce count, and r stable between pulses.
